// File: rtl/pipeline_cpu.sv
// ----------------------------------------------------------------------------
// pipeline_cpu
//   Five-stage in-order MIPS32-subset core (IF/ID/EX/MEM/WB) with private
//   word-addressed instruction and data RAMs. It runs the program held in
//   instruction RAM and drains when the HALT word (32'hFFFFFFFF) is decoded.
//   Branches and jumps resolve in ID with no delay slot. EX has full
//   forwarding. Load-use and branch-dependency hazards insert stalls.
//
// Parameters
//   IMEM_WORDS  instruction RAM depth in 32-bit words
//   DMEM_WORDS  data RAM depth in 32-bit words
//   IMEM_FILE   name of the instruction RAM image (preloaded externally)
//
// Ports
//   CLOCK   in   1   single clock, all state changes on posedge
//   RESET   in   1   asynchronous active-low reset
//   HALTED  out  1   set once the halt marker reaches WB, sticky until reset
//   PC_OUT  out  32  IF-stage program counter (byte address)
//
// Optional feature
//   Define CPU_TRACE_EN to print a per-cycle trace and a register dump when
//   HALTED rises. Cycle behaviour is the same whether or not it is defined.
// ----------------------------------------------------------------------------
module pipeline_cpu #(
    parameter int    IMEM_WORDS = 512,
    parameter int    DMEM_WORDS = 512,
    parameter string IMEM_FILE  = "instructions.bin"
) (
    input  logic        CLOCK,
    input  logic        RESET,
    output logic        HALTED,
    output logic [31:0] PC_OUT
);

    localparam int IA_W = $clog2(IMEM_WORDS);
    localparam int DA_W = $clog2(DMEM_WORDS);
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    localparam logic [5:0] OP_RTYPE = 6'd0,  OP_J    = 6'd2,  OP_JAL  = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4,  OP_BNE  = 6'd5,  OP_ADDI = 6'd8;
    localparam logic [5:0] OP_ADDIU = 6'd9,  OP_SLTI = 6'd10, OP_ANDI = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13, OP_XORI = 6'd14, OP_LW   = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] F_SLL  = 6'd0,  F_SRL  = 6'd2,  F_SRA  = 6'd3;
    localparam logic [5:0] F_SLLV = 6'd4,  F_SRLV = 6'd6,  F_SRAV = 6'd7;
    localparam logic [5:0] F_JR   = 6'd8,  F_ADD  = 6'd32, F_ADDU = 6'd33;
    localparam logic [5:0] F_SUB  = 6'd34, F_SUBU = 6'd35, F_AND  = 6'd36;
    localparam logic [5:0] F_OR   = 6'd37, F_XOR  = 6'd38, F_NOR  = 6'd39;
    localparam logic [5:0] F_SLT  = 6'd42, F_SLTU = 6'd43;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
    } alu_op_t;

    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    alu_imm;    // operand B is the immediate instead of rt
        logic    shift_var;  // shift amount from rs[4:0] instead of shamt
        alu_op_t alu_op;
        logic    halt;       // halt marker riding down as a NOP
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    function automatic logic [31:0] alu(input alu_op_t op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [4:0] sh);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_NOR:  return ~(a | b);
            ALU_SLT:  return {31'b0, sa < sb};
            ALU_SLTU: return {31'b0, a < b};
            ALU_SLL:  return b << sh;
            ALU_SRL:  return b >> sh;
            ALU_SRA:  return sb >>> sh;
            default:  return '0;
        endcase
    endfunction

    // Memories and architectural registers
    logic [31:0] imem [IMEM_WORDS];
    logic [31:0] dmem [DMEM_WORDS] = '{default: '0};
    logic [31:0] regs [32];

    // Pipeline state
    logic [31:0] pc;
    logic [31:0] instr_p1, pc4_p1;
    ctrl_t       ctrl_p2;
    logic [31:0] rs_val_p2, rt_val_p2, imm_p2;
    logic [4:0]  rs_p2, rt_p2, dst_p2, shamt_p2;
    logic        reg_write_p3, mem_read_p3, mem_write_p3, halt_p3;
    logic [4:0]  dst_p3;
    logic [31:0] alu_p3, store_p3;
    logic        reg_write_p4, mem_read_p4, halt_p4;
    logic [4:0]  dst_p4;
    logic [31:0] alu_p4, load_p4;
    logic        halted_q;

    // ---------------- IF ----------------
    logic [31:0] pc4_f, instr_f;
    assign pc4_f   = pc + 32'd4;
    assign instr_f = imem[pc[IA_W+1:2]];
    assign PC_OUT  = pc;

    // ---------------- WB (needed early for the regfile bypass) ----------------
    logic        wb_write;
    logic [31:0] wb_data;
    assign wb_data  = mem_read_p4 ? load_p4 : alu_p4;
    assign wb_write = reg_write_p4 && (dst_p4 != 5'd0);

    // ---------------- ID ----------------
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16;
    logic [31:0] imm_s, imm_z;
    assign op    = instr_p1[31:26];
    assign rs    = instr_p1[25:21];
    assign rt    = instr_p1[20:16];
    assign rd    = instr_p1[15:11];
    assign shamt = instr_p1[10:6];
    assign funct = instr_p1[5:0];
    assign imm16 = instr_p1[15:0];
    assign imm_s = {{16{imm16[15]}}, imm16};
    assign imm_z = {16'b0, imm16};

    logic        halt_d;
    ctrl_t       ctrl_d;
    logic [4:0]  dst_d;
    logic [31:0] imm_d;
    logic        uses_rs, uses_rt, is_beq, is_bne, is_jr, is_jmp;

    assign halt_d = (instr_p1 == HALT_WORD);

    always_comb begin
        ctrl_d      = CTRL_NOP;
        ctrl_d.halt = halt_d;
        dst_d       = 5'd0;
        imm_d       = imm_s;
        uses_rs     = 1'b0;
        uses_rt     = 1'b0;
        is_beq      = 1'b0;
        is_bne      = 1'b0;
        is_jr       = 1'b0;
        is_jmp      = 1'b0;
        if (!halt_d) begin
            case (op)
                OP_RTYPE: begin
                    uses_rs          = 1'b1;
                    uses_rt          = 1'b1;
                    dst_d            = rd;
                    ctrl_d.reg_write = 1'b1;
                    case (funct)
                        F_SLL:          ctrl_d.alu_op = ALU_SLL;
                        F_SRL:          ctrl_d.alu_op = ALU_SRL;
                        F_SRA:          ctrl_d.alu_op = ALU_SRA;
                        F_SLLV: begin   ctrl_d.alu_op = ALU_SLL; ctrl_d.shift_var = 1'b1; end
                        F_SRLV: begin   ctrl_d.alu_op = ALU_SRL; ctrl_d.shift_var = 1'b1; end
                        F_SRAV: begin   ctrl_d.alu_op = ALU_SRA; ctrl_d.shift_var = 1'b1; end
                        F_ADD, F_ADDU:  ctrl_d.alu_op = ALU_ADD;
                        F_SUB, F_SUBU:  ctrl_d.alu_op = ALU_SUB;
                        F_AND:          ctrl_d.alu_op = ALU_AND;
                        F_OR:           ctrl_d.alu_op = ALU_OR;
                        F_XOR:          ctrl_d.alu_op = ALU_XOR;
                        F_NOR:          ctrl_d.alu_op = ALU_NOR;
                        F_SLT:          ctrl_d.alu_op = ALU_SLT;
                        F_SLTU:         ctrl_d.alu_op = ALU_SLTU;
                        F_JR: begin
                            ctrl_d.reg_write = 1'b0;
                            uses_rt          = 1'b0;
                            is_jr            = 1'b1;
                        end
                        default: begin
                            ctrl_d.reg_write = 1'b0;
                            uses_rs          = 1'b0;
                            uses_rt          = 1'b0;
                        end
                    endcase
                end
                OP_J:   is_jmp = 1'b1;
                // jal computes its link value in EX as 0 + (PC+4)
                OP_JAL: begin
                    is_jmp           = 1'b1;
                    ctrl_d.reg_write = 1'b1;
                    ctrl_d.alu_imm   = 1'b1;
                    dst_d            = 5'd31;
                    imm_d            = pc4_p1;
                end
                OP_BEQ: begin is_beq = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; end
                OP_BNE: begin is_bne = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; end
                OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LW: begin
                    uses_rs          = 1'b1;
                    ctrl_d.reg_write = 1'b1;
                    ctrl_d.alu_imm   = 1'b1;
                    dst_d            = rt;
                    ctrl_d.mem_read  = (op == OP_LW);
                    case (op)
                        OP_SLTI: ctrl_d.alu_op = ALU_SLT;
                        OP_ANDI: begin ctrl_d.alu_op = ALU_AND; imm_d = imm_z; end
                        OP_ORI:  begin ctrl_d.alu_op = ALU_OR;  imm_d = imm_z; end
                        OP_XORI: begin ctrl_d.alu_op = ALU_XOR; imm_d = imm_z; end
                        default: ctrl_d.alu_op = ALU_ADD;
                    endcase
                end
                OP_SW: begin
                    uses_rs          = 1'b1;
                    uses_rt          = 1'b1;
                    ctrl_d.mem_write = 1'b1;
                    ctrl_d.alu_imm   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Register read with write-through from WB
    logic [31:0] rs_rf, rt_rf;
    assign rs_rf = (rs == 5'd0) ? 32'd0 : (wb_write && dst_p4 == rs) ? wb_data : regs[rs];
    assign rt_rf = (rt == 5'd0) ? 32'd0 : (wb_write && dst_p4 == rt) ? wb_data : regs[rt];

    // Branch/jr operands may come from a non-load result sitting in MEM
    logic        mem_fwd_ok;
    logic [31:0] br_a, br_b, target;
    logic        taken;
    assign mem_fwd_ok = reg_write_p3 && !mem_read_p3 && (dst_p3 != 5'd0);
    assign br_a  = (mem_fwd_ok && dst_p3 == rs) ? alu_p3 : rs_rf;
    assign br_b  = (mem_fwd_ok && dst_p3 == rt) ? alu_p3 : rt_rf;
    assign taken = is_jmp || is_jr || (is_beq && br_a == br_b) || (is_bne && br_a != br_b);
    assign target = is_jr  ? br_a :
                    is_jmp ? {pc4_p1[31:28], instr_p1[25:0], 2'b00} :
                             pc4_p1 + {imm_s[29:0], 2'b00};

    // Hazard detection: a stall always overrides a taken branch this cycle
    logic hit_ex, hit_mem_load, load_use, stall, redirect;
    assign hit_ex = ctrl_p2.reg_write && (dst_p2 != 5'd0) &&
                    ((uses_rs && dst_p2 == rs) || (uses_rt && dst_p2 == rt));
    assign hit_mem_load = mem_read_p3 && (dst_p3 != 5'd0) &&
                          ((uses_rs && dst_p3 == rs) || (uses_rt && dst_p3 == rt));
    assign load_use = ctrl_p2.mem_read && hit_ex;
    assign stall    = load_use || ((is_beq || is_bne || is_jr) && (hit_ex || hit_mem_load));
    assign redirect = taken && !stall;

    // ---------------- PC and IF/ID ----------------
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            pc       <= '0;
            instr_p1 <= '0;
            pc4_p1   <= '0;
        end else if (!(halt_d || stall)) begin
            if (redirect) begin
                pc       <= target;
                instr_p1 <= '0;
                pc4_p1   <= '0;
            end else begin
                pc       <= pc4_f;
                instr_p1 <= instr_f;
                pc4_p1   <= pc4_f;
            end
        end
    end

    // ---------------- ID/EX ----------------
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            ctrl_p2   <= CTRL_NOP;
            rs_val_p2 <= '0;
            rt_val_p2 <= '0;
            imm_p2    <= '0;
            rs_p2     <= '0;
            rt_p2     <= '0;
            dst_p2    <= '0;
            shamt_p2  <= '0;
        end else begin
            ctrl_p2   <= stall ? CTRL_NOP : ctrl_d;
            dst_p2    <= stall ? 5'd0 : dst_d;
            rs_p2     <= (uses_rs && !stall) ? rs : 5'd0;
            rt_p2     <= (uses_rt && !stall) ? rt : 5'd0;
            rs_val_p2 <= uses_rs ? rs_rf : 32'd0;
            rt_val_p2 <= uses_rt ? rt_rf : 32'd0;
            imm_p2    <= imm_d;
            shamt_p2  <= shamt;
        end
    end

    // ---------------- EX ----------------
    logic        fwd_mem_a, fwd_mem_b, fwd_wb_a, fwd_wb_b;
    logic [31:0] op_a, rt_fwd, alu_b, alu_res;
    logic [4:0]  sh_ex;
    assign fwd_mem_a = reg_write_p3 && (dst_p3 != 5'd0) && (dst_p3 == rs_p2);
    assign fwd_mem_b = reg_write_p3 && (dst_p3 != 5'd0) && (dst_p3 == rt_p2);
    assign fwd_wb_a  = wb_write && (dst_p4 == rs_p2);
    assign fwd_wb_b  = wb_write && (dst_p4 == rt_p2);
    assign op_a   = fwd_mem_a ? alu_p3 : fwd_wb_a ? wb_data : rs_val_p2;
    assign rt_fwd = fwd_mem_b ? alu_p3 : fwd_wb_b ? wb_data : rt_val_p2;
    assign alu_b  = ctrl_p2.alu_imm ? imm_p2 : rt_fwd;
    assign sh_ex  = ctrl_p2.shift_var ? op_a[4:0] : shamt_p2;
    assign alu_res = alu(ctrl_p2.alu_op, op_a, alu_b, sh_ex);

    // ---------------- EX/MEM ----------------
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            reg_write_p3 <= 1'b0;
            mem_read_p3  <= 1'b0;
            mem_write_p3 <= 1'b0;
            halt_p3      <= 1'b0;
            dst_p3       <= '0;
            alu_p3       <= '0;
            store_p3     <= '0;
        end else begin
            reg_write_p3 <= ctrl_p2.reg_write;
            mem_read_p3  <= ctrl_p2.mem_read;
            mem_write_p3 <= ctrl_p2.mem_write;
            halt_p3      <= ctrl_p2.halt;
            dst_p3       <= dst_p2;
            alu_p3       <= alu_res;
            store_p3     <= rt_fwd;
        end
    end

    // ---------------- MEM ----------------
    logic [31:0] load_data;
    assign load_data = dmem[alu_p3[DA_W+1:2]];

    always_ff @(posedge CLOCK) begin
        if (mem_write_p3) dmem[alu_p3[DA_W+1:2]] <= store_p3;
    end

    // ---------------- MEM/WB ----------------
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            reg_write_p4 <= 1'b0;
            mem_read_p4  <= 1'b0;
            halt_p4      <= 1'b0;
            dst_p4       <= '0;
            alu_p4       <= '0;
            load_p4      <= '0;
        end else begin
            reg_write_p4 <= reg_write_p3;
            mem_read_p4  <= mem_read_p3;
            halt_p4      <= halt_p3;
            dst_p4       <= dst_p3;
            alu_p4       <= alu_p3;
            load_p4      <= load_data;
        end
    end

    // ---------------- WB: register file and halt flag ----------------
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wb_write) begin
            regs[dst_p4] <= wb_data;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) halted_q <= 1'b0;
        else if (halt_p4) halted_q <= 1'b1;
    end

    // HALTED is visible in the same cycle the marker occupies WB
    assign HALTED = halted_q | halt_p4;

`ifdef CPU_TRACE_EN
    logic [31:0] trace_cycle;
    logic        halted_prev;
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            trace_cycle <= '0;
            halted_prev <= 1'b0;
        end else begin
            trace_cycle <= trace_cycle + 32'd1;
            halted_prev <= HALTED;
            $display("cyc %0d pc=%h id=%h ex a=%h b=%h res=%h wb %0d<=%h %0d",
                     trace_cycle, pc, instr_p1, op_a, alu_b, alu_res,
                     dst_p4, wb_data, wb_write);
            if (HALTED && !halted_prev) begin
                for (int i = 0; i < 32; i++) $display("  $%0d = %h", i, regs[i]);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_cpu.sv
// ----------------------------------------------------------------------------
// tb_pipeline_cpu
//   Directed bench for pipeline_cpu. Loads a hand-assembled program into the
//   instruction RAM, checks PC_OUT and HALTED every cycle against a
//   hand-derived timeline (stalls, flushes, jal/jr, halt drain), then checks
//   final register and data RAM contents and a mid-run reset.
// ----------------------------------------------------------------------------
module tb_pipeline_cpu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        halted;
    logic [31:0] pc_out;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    pipeline_cpu #(
        .IMEM_WORDS(512),
        .DMEM_WORDS(512),
        .IMEM_FILE ("")
    ) dut (
        .CLOCK (clk),
        .RESET (rst_n),
        .HALTED(halted),
        .PC_OUT(pc_out)
    );

    function automatic logic [31:0] ri(input int op, input int rs, input int rt, input int imm);
        return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    function automatic logic [31:0] rr(input int rs, input int rt, input int rd,
                                       input int sh, input int fn);
        return {6'd0, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
    endfunction

    function automatic logic [31:0] jj(input int op, input int tgt);
        return {op[5:0], tgt[25:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [31:0] prog [23];
    // PC_OUT after each clock edge following reset release (stall at 6/7,
    // branch-dependency stall at 9/10, redirects at 11, 13, 16, halt freeze at 25+)
    int exp_pc [28] = '{4, 8, 12, 16, 20, 24, 24, 28, 32, 32, 40, 44, 80, 84,
                        88, 44, 48, 52, 56, 60, 64, 68, 72, 76, 80, 80, 80, 80};
    int          exp_reg_idx [20] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10,
                                      11, 12, 13, 14, 15, 16, 17, 18, 19, 31};
    logic [31:0] exp_reg_val [20] = '{32'd5, 32'd7, 32'd12, 32'd12, 32'd24, 32'd1,
                                      32'hFFFF_FFFF, 32'd0, 32'd0, 32'd3, 32'd0,
                                      32'h0000_8000, 32'hFFFF_FFF8, 32'hFFFF_FFFC,
                                      32'h01FF_FFFF, 32'd1, 32'd0, 32'hFFFF_0007,
                                      32'd0, 32'd44};

    initial begin
        int nz;
        rst_n = 1'b0;

        prog[0]  = ri(8, 0, 1, 5);            // addi $1,$0,5
        prog[1]  = ri(8, 0, 2, 7);            // addi $2,$0,7
        prog[2]  = rr(1, 2, 3, 0, 32);        // add  $3,$1,$2
        prog[3]  = ri(43, 0, 3, 8);           // sw   $3,8($0)
        prog[4]  = ri(35, 0, 4, 8);           // lw   $4,8($0)
        prog[5]  = rr(4, 4, 5, 0, 32);        // add  $5,$4,$4
        prog[6]  = ri(8, 0, 6, 1);            // addi $6,$0,1
        prog[7]  = ri(4, 6, 6, 2);            // beq  $6,$6,+2
        prog[8]  = ri(8, 0, 8, 99);           // skipped
        prog[9]  = ri(8, 0, 9, 99);           // skipped
        prog[10] = jj(3, 20);                 // jal  word 20
        prog[11] = rr(0, 6, 7, 0, 34);        // sub  $7,$0,$6
        prog[12] = ri(13, 0, 12, 16'h8000);   // ori  $12,$0,0x8000
        prog[13] = ri(8, 0, 13, -8);          // addi $13,$0,-8
        prog[14] = rr(0, 13, 14, 1, 3);       // sra  $14,$13,1
        prog[15] = rr(2, 13, 15, 0, 6);       // srlv $15,$13,$2
        prog[16] = rr(13, 6, 16, 0, 42);      // slt  $16,$13,$6
        prog[17] = rr(13, 6, 17, 0, 43);      // sltu $17,$13,$6
        prog[18] = ri(14, 13, 18, 16'hFFFF);  // xori $18,$13,0xFFFF
        prog[19] = 32'hFFFF_FFFF;             // HALT
        prog[20] = ri(8, 0, 10, 3);           // addi $10,$0,3
        prog[21] = rr(31, 0, 0, 0, 8);        // jr   $31
        prog[22] = ri(8, 0, 11, 77);          // flushed by jr

        for (int i = 0; i < 512; i++) dut.imem[i] = 32'd0;
        for (int i = 0; i < 23; i++) dut.imem[i] = prog[i];

        #12;
        chk("rst_pc", pc_out, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        nz = 0;
        for (int i = 0; i < 32; i++) if (dut.regs[i] !== 32'd0) nz++;
        chk("rst_regs_nonzero", nz, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        chk("rel_pc", pc_out, 32'd0);

        for (int s = 1; s <= 28; s++) begin
            step();
            chk($sformatf("pc_c%0d", s), pc_out, exp_pc[s-1]);
            chk($sformatf("halted_c%0d", s), {31'd0, halted}, (s >= 28) ? 32'd1 : 32'd0);
        end
        for (int s = 29; s <= 30; s++) begin
            step();
            chk($sformatf("pc_frozen_c%0d", s), pc_out, 32'd80);
            chk($sformatf("halted_sticky_c%0d", s), {31'd0, halted}, 32'd1);
        end

        for (int i = 0; i < 20; i++)
            chk($sformatf("reg%0d", exp_reg_idx[i]), dut.regs[exp_reg_idx[i]], exp_reg_val[i]);
        chk("dmem2", dut.dmem[2], 32'd12);

        // Asynchronous reset in the middle of a cycle
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pc", pc_out, 32'd0);
        chk("mid_rst_halted", {31'd0, halted}, 32'd0);
        chk("mid_rst_reg3", dut.regs[3], 32'd0);
        chk("mid_rst_reg31", dut.regs[31], 32'd0);
        chk("mid_rst_dmem_kept", dut.dmem[2], 32'd12);

        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 1; s <= 28; s++) begin
            step();
            if (s == 5)  chk("rerun_pc_c5", pc_out, 32'd20);
            if (s == 27) chk("rerun_halted_c27", {31'd0, halted}, 32'd0);
        end
        chk("rerun_halted_c28", {31'd0, halted}, 32'd1);
        chk("rerun_pc_c28", pc_out, 32'd80);
        chk("rerun_reg5", dut.regs[5], 32'd24);
        chk("rerun_reg7", dut.regs[7], 32'hFFFF_FFFF);
        chk("rerun_reg31", dut.regs[31], 32'd44);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
